// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared status codes, FSM encoding and defaults for the memory bus controller
// Status codes are also decoded by the pipeline freeze stage.
package mem_pkg;

  localparam logic [2:0] ST_FREE  = 3'b010;
  localparam logic [2:0] ST_STALL = 3'b111;
  localparam logic [2:0] ST_FAULT = 3'b101;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } mem_fsm_e;

  // Status code seen by the freeze stage for each controller state.
  function automatic logic [2:0] status_of(input mem_fsm_e s);
    case (s)
      S_BUSY:  return ST_STALL;
      S_FAULT: return ST_FAULT;
      default: return ST_FREE;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - external memory request/acknowledge bus
// master: controller side (drives req/we/addr/wdata/be, receives ack/rdata)
// slave:  memory side (receives the request, drives ack/rdata)
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_align_chk.sv
// rtl/mem_align_chk.sv - combinational misalignment check of a CPU request
// addr_lsb_i   : low two bits of the byte address
// be_i         : byte enables
// misaligned_o : full-word enable off a word boundary, or two-byte enable on an odd address
module mem_align_chk #(
  parameter int BE_W = 4
) (
  input  logic [1:0]      addr_lsb_i,
  input  logic [BE_W-1:0] be_i,
  output logic            misaligned_o
);
  logic word_en;
  logic half_en;

  always_comb begin
    word_en      = &be_i;
    half_en      = ($countones(be_i) == 2);
    misaligned_o = (word_en && (addr_lsb_i != 2'b00)) || (half_en && addr_lsb_i[0]);
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - single-outstanding memory bus controller with timeout and sticky fault
// clk, rst          : clock, asynchronous active-high reset
// cpu_req_i..cpu_be_i: CPU request, sampled only while idle
// cpu_rdata_o        : load data, updated on load completion and held
// cpu_done_o         : one-cycle completion pulse
// state_o            : FREE / STALL / FAULT code for the freeze stage
// fault_o            : sticky fault, cleared only by rst
// bus                : memory request/acknowledge bus (master side)
module mem_bus_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic [DATA_W/8-1:0] cpu_be_i,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  output logic                cpu_done_o,
  output logic [2:0]          state_o,
  output logic                fault_o,
  mem_bus_ctrl_if.master      bus
);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_fsm_e            fsm_q, fsm_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                misaligned;

  mem_align_chk #(.BE_W(BE_W)) u_align_chk (
    .addr_lsb_i   (cpu_addr_i[1:0]),
    .be_i         (cpu_be_i),
    .misaligned_o (misaligned)
  );

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    case (fsm_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          // A misaligned request never reaches the bus.
          if (misaligned) begin
            fsm_d = S_FAULT;
          end else begin
            mem_we_d    = cpu_we_i;
            mem_addr_d  = cpu_addr_i;
            mem_wdata_d = cpu_wdata_i;
            mem_be_d    = cpu_be_i;
            cnt_d       = '0;
            fsm_d       = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // Ack takes priority over a timeout on the same edge.
        if (bus.mem_ack) begin
          if (!mem_we_q) rdata_d = bus.mem_rdata;
          fsm_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fsm_d = S_FAULT;
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      S_FAULT: fsm_d = S_FAULT;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
    end
  end

  // Decoded straight from the state register so rst drops mem_req without a clock.
  assign bus.mem_req   = (fsm_q == S_BUSY);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign cpu_rdata_o = rdata_q;
  assign cpu_done_o  = (fsm_q == S_DONE);
  assign fault_o     = (fsm_q == S_FAULT);
  assign state_o     = status_of(fsm_q);
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl
module tb_mem_bus_ctrl;
  import mem_pkg::*;

  localparam int TIMEOUT = 4;

  typedef struct {
    bit          fault;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic [2:0]  state;
  logic        fault;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = '0;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = '0;
  bit          stray_ack = 1'b0;
  logic [3:0]  be_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h8, 4'h6, 4'h0};

  mem_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_be_i    (cpu_be),
    .cpu_rdata_o (cpu_rdata),
    .cpu_done_o  (cpu_done),
    .state_o     (state),
    .fault_o     (fault),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference alignment rule: four enabled bytes need a word boundary, two need an even address.
  function automatic bit ref_misaligned(input logic [31:0] addr, input logic [3:0] be);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(be[i]);
    if (n == 4) return (addr % 4) != 0;
    if (n == 2) return (addr % 2) != 0;
    return 1'b0;
  endfunction

  // Memory responder: acks after cur_delay BUSY cycles; stray acks outside BUSY.
  initial begin
    int busy_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        bus.mem_ack   = (busy_cnt == cur_delay);
        bus.mem_rdata = bus.mem_ack ? cur_rdata : $urandom;
        busy_cnt++;
      end else begin
        busy_cnt      = 0;
        bus.mem_ack   = stray_ack || (cpu_done && ($urandom_range(0, 1) == 1));
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations on completion/fault and checks bus and status every cycle.
  initial begin
    exp_t        e;
    bit          prev_done = 1'b0;
    bit          fault_seen = 1'b0;
    int          busy_seen = 0;
    logic [31:0] hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0; fault_seen = 1'b0; busy_seen = 0; hold = '0;
      end else begin
        if (bus.mem_req) begin
          busy_seen++;
          chk("stall_code", state, ST_STALL);
          if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
          else chk("bus_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be},
                   {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata, exp_q[0].be});
        end
        if (cpu_done) begin
          chk("done_single", prev_done, 0);
          chk("done_code", state, ST_FREE);
          if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("done_kind", e.fault, 0);
            chk("load_data", cpu_rdata, e.rdata);
            chk("busy_cycles", busy_seen, e.busy);
            hold = e.rdata;
          end
          busy_seen = 0;
        end else if (fault) begin
          chk("fault_code", state, ST_FAULT);
          chk("fault_no_req", bus.mem_req, 0);
          if (!fault_seen) begin
            fault_seen = 1'b1;
            if (exp_q.size() == 0) chk("unexpected_fault", 1, 0);
            else begin
              e = exp_q.pop_front();
              chk("fault_kind", e.fault, 1);
              chk("busy_cycles", busy_seen, e.busy);
            end
          end
          chk("rdata_hold", cpu_rdata, hold);
        end else begin
          if (!bus.mem_req) chk("free_code", state, ST_FREE);
          chk("rdata_hold", cpu_rdata, hold);
        end
        prev_done = cpu_done;
      end
    end
  end

  task automatic drive_garbage();
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    cpu_be    = 4'($urandom);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_state", state, ST_FREE);
    chk("rst_done", cpu_done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_bus_regs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}, 0);
    exp_q.delete();
    model_rdata = '0;
    @(negedge clk);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one request (caller is at posedge+1 with the controller idle) and awaits its outcome.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int delay, input logic [31:0] rdata);
    exp_t e;
    int   cyc;
    int   exp_cyc;
    bit   fin;
    e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.rdata = model_rdata;
    if (ref_misaligned(addr, be)) begin
      e.fault = 1'b1; e.busy = 0; exp_cyc = 1;
    end else if (delay < TIMEOUT) begin
      e.fault = 1'b0; e.busy = delay + 1; exp_cyc = delay + 2;
      if (!we) model_rdata = rdata;
      e.rdata = model_rdata;
    end else begin
      e.fault = 1'b1; e.busy = TIMEOUT; exp_cyc = TIMEOUT + 1;
    end
    exp_q.push_back(e);
    cur_delay = delay;
    cur_rdata = rdata;
    chk("idle_before_req", {state, cpu_done, fault}, {ST_FREE, 1'b0, 1'b0});
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    @(posedge clk); #1;
    drive_garbage();
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 3 * TIMEOUT + 10) begin
      @(negedge clk);
      cyc++;
      if (cpu_done || fault) fin = 1'b1;
      else begin
        @(posedge clk); #1;
        drive_garbage();
      end
    end
    chk("latency", cyc, exp_cyc);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (e.fault || fault) begin
      repeat ($urandom_range(2, 5)) begin
        @(negedge clk);
        stray_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      stray_ack = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    exp_t e;
    bit   we;
    logic [31:0] addr;
    do_reset();

    do_txn(1'b0, 32'h100, 32'h0, 4'hF, 2, 32'hDEADBEEF);
    do_txn(1'b1, 32'h204, 32'h12345678, 4'hF, 0, 32'hA5A5A5A5);
    do_txn(1'b0, 32'h102, 32'h0, 4'hF, 0, 32'h11111111);
    do_txn(1'b0, 32'h40, 32'h0, 4'hF, 100, 32'h22222222);
    do_txn(1'b0, 32'h44, 32'h0, 4'hF, TIMEOUT - 1, 32'hCAFEF00D);
    do_txn(1'b0, 32'h102, 32'h0, 4'hC, 1, 32'h0BADF00D);
    do_txn(1'b1, 32'h101, 32'h55, 4'h3, 0, 32'h0);

    // Reset while BUSY, then a stray ack in IDLE, then a normal request.
    e.fault = 1'b0; e.we = 1'b0; e.addr = 32'h300; e.wdata = 32'h0; e.be = 4'hF;
    e.rdata = model_rdata; e.busy = 0;
    exp_q.push_back(e);
    cur_delay = 100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300; cpu_wdata = 32'h0; cpu_be = 4'hF;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("req_before_rst", bus.mem_req, 1);
    do_reset();
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    @(posedge clk); #1;
    do_txn(1'b0, 32'h308, 32'h0, 4'hF, 1, 32'h600DCAFE);

    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      do_txn(we, addr, $urandom, be_tab[$urandom_range(0, 6)],
             $urandom_range(0, TIMEOUT + 1), $urandom);
    end

    chk("queue_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
